vdp18_access_sched: RTL and testbench
=====================================

Name: vdp18_access_sched

Overview:
- Per-pixel VRAM slot scheduler for the TMS9918A-class VDP.
- Decides, once per memory slot, which access type (pattern name/colour/generator, sprite test, sprite attribute/pattern fetch, CPU or none) owns VRAM.
- Sequences sprite-number and sprite-index counters and hands free slots to the CPU port with a request/acknowledge handshake.
- Output feeds the VRAM address multiplexer and the VRAM read/write strobe logic.

Parameters:
- SPR_PER_LINE, 4, sprites fetched per line (sets spr_idx width and fetch-window length).
- HBLANK_PIX, 86, pixels of horizontal blank preceding num_pix_i = 0 (num_pix_i runs -HBLANK_PIX..255).

Ports:
- clock_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- clk_en_5m37_i  in  1  pixel-clock enable.
- opmode_i  in  opmode_t  current display mode.
- reg_blank_i  in  1  1 = display enabled (R1 BL).
- num_pix_i  in  signed 9  horizontal pixel position.
- num_line_i  in  signed 9  vertical line; active lines are 0..191.
- spr_stop_i  in  1  sprite unit signals terminator (Y=0xD0) or 5th sprite found; ends test.
- spr_found_i  in  3  number of sprites found for the next line (0..4).
- cpu_req_i  in  1  level request from the CPU I/O block.
- access_type_o  out  access_t  registered slot owner.
- spr_num_o  out  5  sprite-attribute index under test.
- spr_idx_o  out  2  found-sprite index being fetched.
- cpu_ack_o  out  1  one-clock pulse: the CPU access has completed.

Behaviour:
- Slot boundary: clk_en_5m37_i = 1 and num_pix_i even. Each slot lasts 2 pixel enables, giving 171 slots per line.
- access_type_o is registered on the slot-boundary clock and held until the next boundary. Latency is 1 clock from the boundary enable.
- Display-active condition: reg_blank_i = 1 and num_line_i in 0..191. If this condition is false, every slot is AC_CPU when cpu_req_i = 1, otherwise AC_NONE.
- Active region (num_pix_i 0..255), phase = num_pix_i bits [2:1]:
  - GRAPH1/GRAPH2: phase 0 PNT, 1 PCT, 2 PGT, 3 STST.
  - MULTIC: phase 0 PNT, 1 CPU/NONE, 2 PGT, 3 STST.
  - TEXTM: phase 0 PNT, 2 PGT, phases 1 and 3 CPU/NONE; no sprite activity.
- Sprite test:
  - spr_num_o clears to 0 at the slot with num_pix_i = 0.
  - spr_num_o increments after each STST slot.
  - Once spr_stop_i is seen, or after the STST slot with spr_num_o = 31, the test is done: remaining phase-3 slots become CPU/NONE and spr_num_o holds.
  - spr_num_o never wraps within a line.
- Horizontal blank (num_pix_i < 0), slot k = (num_pix_i + HBLANK_PIX) / 2:
  - k 0..5*SPR_PER_LINE-1 is the fetch window. Sprite s = k/5, sub-slot k mod 5 maps to SATX, SATN, SATC, SPTH, SPTL.
  - spr_idx_o = s. Fetch happens only if s < spr_found_i; otherwise the slot is CPU/NONE.
  - Remaining blank slots are CPU/NONE.
  - Sprite fetch is suppressed in TEXTM.
- CPU handshake:
  - cpu_req_i is sampled only at slot boundaries.
  - A granted slot drives AC_CPU. cpu_ack_o pulses for 1 clock on the clock after the next slot boundary (slot end).
  - After the ack, the CPU block must drop cpu_req_i before the following boundary or it is granted again.
  - A request arriving mid-slot waits for the next free slot.
  - There is never more than one outstanding grant.
- Mode or reg_blank_i change takes effect at the next boundary. Any in-flight CPU slot completes and is acked.
- Reset (asynchronous, any time): access_type_o = AC_NONE, cpu_ack_o = 0, spr_num_o = 0, spr_idx_o = 0, test-done flag = 0, pending grant discarded with no ack.
- No state advances while clk_en_5m37_i = 0 except the cpu_ack_o deassert.

Decomposition:
- access_t and opmode_t come from vdp18_pkg.
- Add to vdp18_pkg: slot-phase constants, SPR_FETCH_SLOTS = 5, and STST_LAST = 31.
- Optional sub-module vdp18_cpu_slot_hs holds the grant flag and ack pulse generator. All other logic stays in one always_ff plus one always_comb.

Test Plan:
- GRAPH2, line 10, blank on, no CPU request:
  - num_pix_i 0,2,4,6 -> access_type_o PNT, PCT, PGT, STST.
  - spr_num_o 0 -> 1 after that slot.
- TEXTM, cpu_req_i held high:
  - num_pix_i 2 -> AC_CPU.
  - cpu_ack_o pulses at 1 clock after the num_pix_i = 4 boundary.
  - No STST at any slot.
- GRAPH1, spr_stop_i asserted after spr_num_o = 7:
  - spr_num_o holds at 7.
  - Later phase-3 slots become AC_NONE, or AC_CPU with a request.
- Blank fetch, spr_found_i = 2:
  - k 0..9 -> SATX, SATN, SATC, SPTH, SPTL twice, with spr_idx_o 0 then 1.
  - k 10..42 -> AC_NONE.
- reg_blank_i = 0 or num_line_i = 200: every slot is AC_NONE, and AC_CPU with a request.
- Reset:
  - reset_n_i low mid CPU slot -> outputs at reset values immediately, no ack.
  - After release, the first boundary schedules normally.

Source files
------------

// File: rtl/vdp18_pkg.sv
// Shared types and constants for the VDP18 VRAM access scheduler.
package vdp18_pkg;

   typedef enum logic [1:0] {
      OP_GRAPH1 = 2'd0,
      OP_GRAPH2 = 2'd1,
      OP_MULTIC = 2'd2,
      OP_TEXTM  = 2'd3
   } opmode_t;

   typedef enum logic [3:0] {
      AC_NONE = 4'd0,
      AC_PNT  = 4'd1,
      AC_PCT  = 4'd2,
      AC_PGT  = 4'd3,
      AC_STST = 4'd4,
      AC_SATX = 4'd5,
      AC_SATN = 4'd6,
      AC_SATC = 4'd7,
      AC_SPTH = 4'd8,
      AC_SPTL = 4'd9,
      AC_CPU  = 4'd10
   } access_t;

   // Slot phase within the active region, taken from num_pix[2:1]
   localparam logic [1:0] PH_PNT  = 2'd0;
   localparam logic [1:0] PH_PCT  = 2'd1;
   localparam logic [1:0] PH_PGT  = 2'd2;
   localparam logic [1:0] PH_STST = 2'd3;

   localparam int unsigned SPR_FETCH_SLOTS = 5;
   localparam int unsigned STST_LAST       = 31;

   typedef enum logic {
      HS_IDLE  = 1'b0,
      HS_GRANT = 1'b1
   } hs_state_t;

endpackage

// File: rtl/vdp18_access_sched_if.sv
// CPU-port request/acknowledge handshake between the CPU I/O block and the scheduler.
interface vdp18_access_sched_if;
   logic cpu_req_i;
   logic cpu_ack_o;

   modport master (output cpu_req_i, input cpu_ack_o);
   modport slave  (input cpu_req_i, output cpu_ack_o);
endinterface

// File: rtl/vdp18_cpu_slot_hs.sv
// Tracks the single outstanding CPU grant and pulses ack when the granted slot ends.
module vdp18_cpu_slot_hs
   import vdp18_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic slot_stb,
   input  logic grant_c,
   output logic busy_c,
   output logic cpu_ack
);

   hs_state_t state, state_nxt;
   logic      ack_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= HS_IDLE;
         cpu_ack <= 1'b0;
      end else begin
         state   <= state_nxt;
         cpu_ack <= ack_nxt;
      end
   end

   // Grant is taken on a boundary; the following boundary closes it and fires ack
   always_comb begin
      state_nxt = state;
      ack_nxt   = 1'b0;
      if (slot_stb) begin
         case (state)
            HS_IDLE: begin
               if (grant_c) state_nxt = HS_GRANT;
            end
            HS_GRANT: begin
               ack_nxt   = 1'b1;
               state_nxt = HS_IDLE;
            end
            default: state_nxt = HS_IDLE;
         endcase
      end
   end

   assign busy_c = (state == HS_GRANT);

endmodule

// File: rtl/vdp18_access_sched.sv
// Per-slot VRAM owner selection: pattern/colour/generator, sprite test and fetch, CPU.
module vdp18_access_sched
   import vdp18_pkg::*;
#(
   parameter int unsigned SPR_PER_LINE = 4,
   parameter int unsigned HBLANK_PIX   = 86
) (
   input  logic                              clock_i,
   input  logic                              reset_n_i,
   input  logic                              clk_en_5m37_i,
   input  opmode_t                           opmode_i,
   input  logic                              reg_blank_i,
   input  logic signed [8:0]                 num_pix_i,
   input  logic signed [8:0]                 num_line_i,
   input  logic                              spr_stop_i,
   input  logic [2:0]                        spr_found_i,
   vdp18_access_sched_if.slave               cpu,
   output access_t                           access_type_o,
   output logic [4:0]                        spr_num_o,
   output logic [$clog2(SPR_PER_LINE)-1:0]   spr_idx_o
);

   localparam int unsigned SPR_IDX_W = $clog2(SPR_PER_LINE);

   logic                 slot_stb;
   logic                 disp_act;
   logic                 busy_c;
   logic                 grant_c;
   logic                 slot_free;
   logic                 test_done, test_done_nxt;
   logic [1:0]           phase;
   logic [9:0]           pix_off;
   logic [6:0]           slot_k;
   logic [6:0]           spr_s;
   logic [2:0]           fetch_sub;
   access_t              acc_nxt;
   logic [4:0]           spr_num_nxt;
   logic [SPR_IDX_W-1:0] spr_idx_nxt;

   assign slot_stb = clk_en_5m37_i & ~num_pix_i[0];
   assign disp_act = reg_blank_i & ~num_line_i[8] & (num_line_i[7:0] < 8'd192);
   assign phase    = num_pix_i[2:1];

   vdp18_cpu_slot_hs u_cpu_hs (
      .clk      (clock_i),
      .rst_n    (reset_n_i),
      .slot_stb (slot_stb),
      .grant_c  (grant_c),
      .busy_c   (busy_c),
      .cpu_ack  (cpu.cpu_ack_o)
   );

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         access_type_o <= AC_NONE;
         spr_num_o     <= '0;
         spr_idx_o     <= '0;
         test_done     <= 1'b0;
      end else if (slot_stb) begin
         access_type_o <= acc_nxt;
         spr_num_o     <= spr_num_nxt;
         spr_idx_o     <= spr_idx_nxt;
         test_done     <= test_done_nxt;
      end
   end

   always_comb begin
      acc_nxt       = AC_NONE;
      spr_num_nxt   = spr_num_o;
      spr_idx_nxt   = spr_idx_o;
      test_done_nxt = test_done;
      slot_free     = 1'b0;
      grant_c       = 1'b0;
      pix_off       = 10'(num_pix_i) + 10'(HBLANK_PIX);
      slot_k        = 7'(pix_off >> 1);
      spr_s         = slot_k / 7'(SPR_FETCH_SLOTS);
      fetch_sub     = 3'(slot_k % 7'(SPR_FETCH_SLOTS));

      // Sprite test bookkeeping: the counter advances as the STST slot closes
      if (num_pix_i == 9'sd0) begin
         spr_num_nxt   = '0;
         test_done_nxt = 1'b0;
      end else begin
         if (access_type_o == AC_STST && !spr_stop_i) begin
            if (spr_num_o == 5'(STST_LAST)) test_done_nxt = 1'b1;
            else                            spr_num_nxt   = spr_num_o + 5'd1;
         end
         if (spr_stop_i) test_done_nxt = 1'b1;
      end

      if (!disp_act) begin
         slot_free = 1'b1;
      end else if (!num_pix_i[8]) begin
         case (phase)
            PH_PNT: acc_nxt = AC_PNT;
            PH_PCT: begin
               if (opmode_i == OP_GRAPH1 || opmode_i == OP_GRAPH2) acc_nxt   = AC_PCT;
               else                                                 slot_free = 1'b1;
            end
            PH_PGT: acc_nxt = AC_PGT;
            PH_STST: begin
               if (opmode_i == OP_TEXTM || test_done_nxt) slot_free = 1'b1;
               else                                        acc_nxt   = AC_STST;
            end
            default: slot_free = 1'b1;
         endcase
      end else if (opmode_i == OP_TEXTM ||
                   slot_k >= 7'(SPR_FETCH_SLOTS * SPR_PER_LINE)) begin
         slot_free = 1'b1;
      end else begin
         spr_idx_nxt = SPR_IDX_W'(spr_s);
         if (spr_s < 7'(spr_found_i)) begin
            case (fetch_sub)
               3'd0:    acc_nxt = AC_SATX;
               3'd1:    acc_nxt = AC_SATN;
               3'd2:    acc_nxt = AC_SATC;
               3'd3:    acc_nxt = AC_SPTH;
               3'd4:    acc_nxt = AC_SPTL;
               default: acc_nxt = AC_NONE;
            endcase
         end else begin
            slot_free = 1'b1;
         end
      end

      // A slot closing an earlier grant is never re-granted
      if (slot_free && cpu.cpu_req_i && !busy_c) begin
         acc_nxt = AC_CPU;
         grant_c = slot_stb;
      end
   end

endmodule

// File: tb/tb_vdp18_access_sched.sv
// Directed bench for vdp18_access_sched: slot-owner table plus handshake/sprite/reset sequences.
module tb_vdp18_access_sched;
   import vdp18_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              clk_en;
   opmode_t           mode;
   logic              blank;
   logic signed [8:0] num_pix;
   logic signed [8:0] num_line;
   logic              spr_stop;
   logic [2:0]        spr_found;
   access_t           access_type;
   logic [4:0]        spr_num;
   logic [1:0]        spr_idx;

   int checks = 0;
   int errors = 0;

   vdp18_access_sched_if cpu_if ();

   vdp18_access_sched dut (
      .clock_i       (clk),
      .reset_n_i     (rst_n),
      .clk_en_5m37_i (clk_en),
      .opmode_i      (mode),
      .reg_blank_i   (blank),
      .num_pix_i     (num_pix),
      .num_line_i    (num_line),
      .spr_stop_i    (spr_stop),
      .spr_found_i   (spr_found),
      .cpu           (cpu_if),
      .access_type_o (access_type),
      .spr_num_o     (spr_num),
      .spr_idx_o     (spr_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      opmode_t    m;
      logic       bl;
      int         ln;
      int         px;
      logic       rq;
      logic [2:0] fnd;
      access_t    ea;
      int         en;
      int         ei;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(opmode_t m, logic bl, int ln, int px, logic rq, int fnd,
                               access_t ea, int en, int ei);
      vec_t v;
      v.m = m; v.bl = bl; v.ln = ln; v.px = px; v.rq = rq; v.fnd = 3'(fnd);
      v.ea = ea; v.en = en; v.ei = ei;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int pix);
      num_pix = 9'(pix);
      clk_en  = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b0; mode = OP_GRAPH2; blank = 1'b1;
      num_pix = '0; num_line = 9'sd10; spr_stop = 1'b0; spr_found = '0;
      cpu_if.cpu_req_i = 1'b0;
      tick(); tick();
      chk("rst_acc", 32'(access_type), 32'(AC_NONE));
      chk("rst_ack", 32'(cpu_if.cpu_ack_o), 0);
      chk("rst_num", 32'(spr_num), 0);
      chk("rst_idx", 32'(spr_idx), 0);
      rst_n = 1'b1;

      // Slot-owner table, applied in order (sprite counters carry between rows)
      vecs.push_back(mk(OP_GRAPH2, 1, 10,   0, 0, 0, AC_PNT,  0, 0));
      vecs.push_back(mk(OP_GRAPH2, 1, 10,   2, 0, 0, AC_PCT,  0, 0));
      vecs.push_back(mk(OP_GRAPH2, 1, 10,   4, 0, 0, AC_PGT,  0, 0));
      vecs.push_back(mk(OP_GRAPH2, 1, 10,   6, 0, 0, AC_STST, 0, 0));
      vecs.push_back(mk(OP_GRAPH2, 1, 10,   8, 0, 0, AC_PNT,  1, 0));
      vecs.push_back(mk(OP_GRAPH2, 1, 10,  14, 0, 0, AC_STST, 1, 0));
      vecs.push_back(mk(OP_GRAPH2, 1, 10,  16, 0, 0, AC_PNT,  2, 0));
      vecs.push_back(mk(OP_MULTIC, 1, 10,  18, 0, 0, AC_NONE, 2, 0));
      vecs.push_back(mk(OP_MULTIC, 1, 10,  20, 0, 0, AC_PGT,  2, 0));
      vecs.push_back(mk(OP_MULTIC, 1, 10,  22, 0, 0, AC_STST, 2, 0));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -86, 0, 2, AC_SATX, 3, 0));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -84, 0, 2, AC_SATN, 3, 0));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -82, 0, 2, AC_SATC, 3, 0));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -80, 0, 2, AC_SPTH, 3, 0));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -78, 0, 2, AC_SPTL, 3, 0));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -76, 0, 2, AC_SATX, 3, 1));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -74, 0, 2, AC_SATN, 3, 1));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -72, 0, 2, AC_SATC, 3, 1));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -70, 0, 2, AC_SPTH, 3, 1));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -68, 0, 2, AC_SPTL, 3, 1));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -66, 0, 2, AC_NONE, 3, 2));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -56, 0, 2, AC_NONE, 3, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 10, -46, 0, 2, AC_NONE, 3, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 10,  -2, 0, 2, AC_NONE, 3, 3));
      vecs.push_back(mk(OP_TEXTM,  1, 10, -56, 0, 2, AC_NONE, 3, 3));
      vecs.push_back(mk(OP_GRAPH1, 0, 10,   0, 0, 2, AC_NONE, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 0, 10,   6, 0, 2, AC_NONE, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 200,  6, 0, 2, AC_NONE, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 200,-56, 0, 2, AC_NONE, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, -1,   0, 0, 2, AC_NONE, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 192,  2, 0, 2, AC_NONE, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 191,  2, 0, 2, AC_PCT,  0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 0,    6, 0, 2, AC_STST, 0, 3));
      vecs.push_back(mk(OP_GRAPH1, 1, 0,    8, 0, 2, AC_PNT,  1, 3));
      vecs.push_back(mk(OP_GRAPH1, 0, 10,  10, 1, 2, AC_CPU,  1, 3));
      vecs.push_back(mk(OP_GRAPH1, 0, 10,  12, 0, 2, AC_NONE, 1, 3));

      foreach (vecs[i]) begin
         mode = vecs[i].m; blank = vecs[i].bl; num_line = 9'(vecs[i].ln);
         cpu_if.cpu_req_i = vecs[i].rq; spr_found = vecs[i].fnd;
         step(vecs[i].px);
         chk($sformatf("vec%0d_acc", i), 32'(access_type), 32'(vecs[i].ea));
         chk($sformatf("vec%0d_num", i), 32'(spr_num), 32'(vecs[i].en));
         chk($sformatf("vec%0d_idx", i), 32'(spr_idx), 32'(vecs[i].ei));
         step(vecs[i].px + 1);
         chk($sformatf("vec%0d_hold", i), 32'(access_type), 32'(vecs[i].ea));
      end

      // TEXTM: request raised mid-slot, grant at phase 1, ack after the closing boundary
      mode = OP_TEXTM; blank = 1'b1; num_line = 9'sd10; cpu_if.cpu_req_i = 1'b0; spr_found = '0;
      step(0);  chk("tx_pnt", 32'(access_type), 32'(AC_PNT));
      cpu_if.cpu_req_i = 1'b1;
      step(1);  chk("tx_ack_a", 32'(cpu_if.cpu_ack_o), 0);
      step(2);  chk("tx_cpu", 32'(access_type), 32'(AC_CPU));
      chk("tx_ack_b", 32'(cpu_if.cpu_ack_o), 0);
      step(3);  chk("tx_ack_c", 32'(cpu_if.cpu_ack_o), 0);
      step(4);  chk("tx_pgt", 32'(access_type), 32'(AC_PGT));
      chk("tx_ack_d", 32'(cpu_if.cpu_ack_o), 1);
      cpu_if.cpu_req_i = 1'b0;
      step(5);  chk("tx_ack_e", 32'(cpu_if.cpu_ack_o), 0);
      step(6);  chk("tx_ph3", 32'(access_type), 32'(AC_NONE));
      chk("tx_num", 32'(spr_num), 0);
      cpu_if.cpu_req_i = 1'b1;
      step(7); step(8);
      step(10); chk("tx_cpu2", 32'(access_type), 32'(AC_CPU));
      step(11);
      step(12); chk("tx_ack_f", 32'(cpu_if.cpu_ack_o), 1);
      step(14); chk("tx_regrant", 32'(access_type), 32'(AC_CPU));
      chk("tx_ack_g", 32'(cpu_if.cpu_ack_o), 0);
      step(15);
      step(16); chk("tx_ack_h", 32'(cpu_if.cpu_ack_o), 1);
      cpu_if.cpu_req_i = 1'b0;
      step(17);

      // GRAPH1: stop during the STST slot testing sprite 7
      mode = OP_GRAPH1;
      for (int p = 0; p < 62; p += 2) begin
         step(p); step(p + 1);
      end
      step(62); chk("st_stst7", 32'(access_type), 32'(AC_STST));
      chk("st_num7", 32'(spr_num), 7);
      spr_stop = 1'b1;
      step(63);
      step(64); chk("st_num_hold", 32'(spr_num), 7);
      spr_stop = 1'b0;
      for (int p = 65; p < 70; p++) step(p);
      step(70); chk("st_ph3_none", 32'(access_type), 32'(AC_NONE));
      chk("st_num_hold2", 32'(spr_num), 7);
      for (int p = 71; p < 78; p++) step(p);
      cpu_if.cpu_req_i = 1'b1;
      step(78); chk("st_ph3_cpu", 32'(access_type), 32'(AC_CPU));
      step(79);
      step(80); chk("st_ack", 32'(cpu_if.cpu_ack_o), 1);
      cpu_if.cpu_req_i = 1'b0;
      step(81);

      // GRAPH2: full line, sprite counter stops at 31 without wrapping
      mode = OP_GRAPH2;
      for (int p = 0; p < 254; p++) step(p);
      step(254); chk("l31_stst", 32'(access_type), 32'(AC_STST));
      chk("l31_num", 32'(spr_num), 31);
      step(255);
      step(-86); chk("l31_nowrap", 32'(spr_num), 31);
      chk("l31_blank", 32'(access_type), 32'(AC_NONE));
      step(-85);

      // Clock enable low: nothing advances
      step(0);  chk("ce_pnt", 32'(access_type), 32'(AC_PNT));
      clk_en = 1'b0; num_pix = 9'sd6; cpu_if.cpu_req_i = 1'b1;
      tick(); tick(); tick();
      chk("ce_hold_acc", 32'(access_type), 32'(AC_PNT));
      chk("ce_hold_ack", 32'(cpu_if.cpu_ack_o), 0);
      cpu_if.cpu_req_i = 1'b0;
      step(2);  chk("ce_resume", 32'(access_type), 32'(AC_PCT));

      // Reset in the middle of a granted CPU slot: no ack afterwards
      blank = 1'b0; cpu_if.cpu_req_i = 1'b1;
      step(20); chk("rs_cpu", 32'(access_type), 32'(AC_CPU));
      step(21);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_acc", 32'(access_type), 32'(AC_NONE));
      chk("rs_ack", 32'(cpu_if.cpu_ack_o), 0);
      chk("rs_num", 32'(spr_num), 0);
      chk("rs_idx", 32'(spr_idx), 0);
      cpu_if.cpu_req_i = 1'b0;
      step(22); chk("rs_ack2", 32'(cpu_if.cpu_ack_o), 0);
      rst_n = 1'b1;
      step(23); chk("rs_ack3", 32'(cpu_if.cpu_ack_o), 0);
      blank = 1'b1; mode = OP_GRAPH2;
      step(0);  chk("rs_pnt", 32'(access_type), 32'(AC_PNT));
      chk("rs_ack4", 32'(cpu_if.cpu_ack_o), 0);
      step(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
